// File: rtl/cpu_pkg.sv
// Shared widths, forwarding-select codes and the producer bundle used by
// the ID/EX operand stage and its bypass selectors.
package cpu_pkg;

    localparam int REG_W   = 5;
    localparam int DATA_W  = 32;
    localparam int CTRL_W  = 12;
    localparam int NUM_SRC = 2;   // Rs and Rt

    typedef enum logic [2:0] {
        FWD_RF,
        FWD_EX,
        FWD_MEM,
        FWD_WB,
        FWD_ZERO
    } fwd_sel_e;

    // One result producer as seen by the bypass network. For EX, 'we' is
    // already qualified so that a load (data not yet available) never hits.
    typedef struct packed {
        logic              we;
        logic [REG_W-1:0]  wr;
        logic [DATA_W-1:0] d;
    } fwd_src_t;

endpackage

// File: rtl/fwd_sel.sv
// Priority bypass select for a single source operand: r0, EX, MEM, WB,
// then register file. Purely combinational.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [REG_W-1:0]  idx,
    input  logic [DATA_W-1:0] rf_d,
    input  fwd_src_t          ex,
    input  fwd_src_t          mem,
    input  fwd_src_t          wb,
    output logic [DATA_W-1:0] d,
    output fwd_sel_e          sel
);

    // Youngest matching producer wins; r0 is hardwired and never bypassed.
    always_comb begin
        d   = rf_d;
        sel = FWD_RF;
        if (idx == '0) begin
            d   = '0;
            sel = FWD_ZERO;
        end else if (ex.we && ex.wr == idx) begin
            d   = ex.d;
            sel = FWD_EX;
        end else if (mem.we && mem.wr == idx) begin
            d   = mem.d;
            sel = FWD_MEM;
        end else if (wb.we && wb.wr == idx) begin
            d   = wb.d;
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: resolves Rs/Rt through the bypass network, raises
// load-use stalls and registers operands plus control for EX.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int CTRL_W = cpu_pkg::CTRL_W
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              IdValid,
    input  logic [REG_W-1:0]  IdRs,
    input  logic [REG_W-1:0]  IdRt,
    input  logic              IdUsesRt,
    input  logic [REG_W-1:0]  IdDst,
    input  logic [DATA_W-1:0] IdImm,
    input  logic [CTRL_W-1:0] IdCtrl,
    input  logic [DATA_W-1:0] Qa,
    input  logic [DATA_W-1:0] Qb,
    input  logic              ExFwdValid,
    input  logic              ExFwdWe,
    input  logic              ExFwdIsLoad,
    input  logic [REG_W-1:0]  ExFwdWr,
    input  logic [DATA_W-1:0] ExFwdD,
    input  logic              MemFwdWe,
    input  logic [REG_W-1:0]  MemFwdWr,
    input  logic [DATA_W-1:0] MemFwdD,
    input  logic              WbWe,
    input  logic [REG_W-1:0]  WbWr,
    input  logic [DATA_W-1:0] WbD,
    input  logic              Hold,
    input  logic              Flush,
    output logic              LoadUseStall,
    output logic              ExValid,
    output logic [DATA_W-1:0] ExA,
    output logic [DATA_W-1:0] ExB,
    output logic [DATA_W-1:0] ExImm,
    output logic [CTRL_W-1:0] ExCtrl,
    output logic [REG_W-1:0]  ExRt,
    output logic [REG_W-1:0]  ExDst
);

    fwd_src_t ex_src, mem_src, wb_src;
    logic [NUM_SRC-1:0][REG_W-1:0]  src_idx;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_rf;
    logic [NUM_SRC-1:0][DATA_W-1:0] src_d;
    fwd_sel_e                       src_sel [NUM_SRC];
    logic                           ex_load_hit;
    logic                           unused_sel;

    // A load in EX has no result yet, so it is masked out of the EX bypass.
    assign ex_src  = '{we: ExFwdValid & ExFwdWe & ~ExFwdIsLoad, wr: ExFwdWr, d: ExFwdD};
    assign mem_src = '{we: MemFwdWe, wr: MemFwdWr, d: MemFwdD};
    assign wb_src  = '{we: WbWe, wr: WbWr, d: WbD};

    assign src_idx = {IdRt, IdRs};
    assign src_rf  = {Qb, Qa};

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_sel u_fwd_sel (
                .idx  (src_idx[i]),
                .rf_d (src_rf[i]),
                .ex   (ex_src),
                .mem  (mem_src),
                .wb   (wb_src),
                .d    (src_d[i]),
                .sel  (src_sel[i])
            );
        end
    endgenerate

    // Select codes are kept for debug probing only.
    assign unused_sel = ^{src_sel[0], src_sel[1]};

    assign ex_load_hit = ExFwdValid & ExFwdWe & ExFwdIsLoad & (ExFwdWr != '0) &
                         ((ExFwdWr == IdRs) | (IdUsesRt & (ExFwdWr == IdRt)));

    // A frozen or killed slot never requests a stall.
    assign LoadUseStall = IdValid & ex_load_hit & ~Hold & ~Flush;

    // Pipeline register: reset > flush > hold > bubble > load.
    always_ff @(posedge Clk) begin
        if (Clr || Flush || (!Hold && LoadUseStall)) begin
            ExValid <= 1'b0;
            ExA     <= '0;
            ExB     <= '0;
            ExImm   <= '0;
            ExCtrl  <= '0;
            ExRt    <= '0;
            ExDst   <= '0;
        end else if (!Hold) begin
            ExValid <= IdValid;
            ExA     <= src_d[0];
            ExB     <= src_d[1];
            ExImm   <= IdImm;
            ExCtrl  <= IdCtrl;
            ExRt    <= IdRt;
            ExDst   <= IdDst;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus a
// randomized run against a behavioural model of the stage.
module tb_id_ex_operand_stage;
    import cpu_pkg::*;

    logic              Clk, Clr, IdValid, IdUsesRt, Hold, Flush;
    logic [4:0]        IdRs, IdRt, IdDst, ExFwdWr, MemFwdWr, WbWr, ExRt, ExDst;
    logic [31:0]       IdImm, Qa, Qb, ExFwdD, MemFwdD, WbD, ExA, ExB, ExImm;
    logic [11:0]       IdCtrl, ExCtrl;
    logic              ExFwdValid, ExFwdWe, ExFwdIsLoad, MemFwdWe, WbWe;
    logic              LoadUseStall, ExValid;

    int passed = 0;
    int total  = 0;

    // model state: what the EX-side registers should hold
    logic        e_valid;
    logic [31:0] e_a, e_b, e_imm;
    logic [11:0] e_ctrl;
    logic [4:0]  e_rt, e_dst;

    id_ex_operand_stage dut (
        .Clk(Clk), .Clr(Clr), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
        .IdUsesRt(IdUsesRt), .IdDst(IdDst), .IdImm(IdImm), .IdCtrl(IdCtrl),
        .Qa(Qa), .Qb(Qb), .ExFwdValid(ExFwdValid), .ExFwdWe(ExFwdWe),
        .ExFwdIsLoad(ExFwdIsLoad), .ExFwdWr(ExFwdWr), .ExFwdD(ExFwdD),
        .MemFwdWe(MemFwdWe), .MemFwdWr(MemFwdWr), .MemFwdD(MemFwdD),
        .WbWe(WbWe), .WbWr(WbWr), .WbD(WbD), .Hold(Hold), .Flush(Flush),
        .LoadUseStall(LoadUseStall), .ExValid(ExValid), .ExA(ExA), .ExB(ExB),
        .ExImm(ExImm), .ExCtrl(ExCtrl), .ExRt(ExRt), .ExDst(ExDst)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Value a source register sees: newest in-flight result, else the file.
    function automatic logic [31:0] m_opnd(input logic [4:0] r, input logic [31:0] rf);
        logic        hit [3];
        logic [31:0] val [3];
        if (r == 5'd0) return 32'h0;
        hit[0] = ExFwdValid && ExFwdWe && !ExFwdIsLoad && ExFwdWr == r; val[0] = ExFwdD;
        hit[1] = MemFwdWe && MemFwdWr == r;                             val[1] = MemFwdD;
        hit[2] = WbWe && WbWr == r;                                     val[2] = WbD;
        for (int k = 0; k < 3; k++) if (hit[k]) return val[k];
        return rf;
    endfunction

    function automatic logic m_stall();
        logic needs_rs, needs_rt;
        if (!IdValid || Hold || Flush) return 1'b0;
        if (!(ExFwdValid && ExFwdWe && ExFwdIsLoad) || ExFwdWr == 5'd0) return 1'b0;
        needs_rs = (ExFwdWr == IdRs);
        needs_rt = IdUsesRt && (ExFwdWr == IdRt);
        return needs_rs || needs_rt;
    endfunction

    // Advance one clock and move the model to its post-edge state.
    task automatic tick();
        logic        n_valid;
        logic [31:0] n_a, n_b, n_imm;
        logic [11:0] n_ctrl;
        logic [4:0]  n_rt, n_dst;
        {n_valid, n_a, n_b, n_imm, n_ctrl, n_rt, n_dst} = {e_valid, e_a, e_b, e_imm, e_ctrl, e_rt, e_dst};
        if (Clr || Flush || (!Hold && m_stall())) begin
            {n_valid, n_a, n_b, n_imm, n_ctrl, n_rt, n_dst} = '0;
        end else if (!Hold) begin
            n_valid = IdValid;
            n_a     = m_opnd(IdRs, Qa);
            n_b     = m_opnd(IdRt, Qb);
            n_imm   = IdImm;
            n_ctrl  = IdCtrl;
            n_rt    = IdRt;
            n_dst   = IdDst;
        end
        @(posedge Clk);
        #1;
        {e_valid, e_a, e_b, e_imm, e_ctrl, e_rt, e_dst} = {n_valid, n_a, n_b, n_imm, n_ctrl, n_rt, n_dst};
    endtask

    task automatic rand_id();
        IdValid  = 1'($urandom_range(0, 3) != 0);
        IdRs     = 5'($urandom_range(0, 3));
        IdRt     = 5'($urandom_range(0, 3));
        IdUsesRt = 1'($urandom);
        IdDst    = 5'($urandom);
        IdImm    = $urandom;
        IdCtrl   = 12'($urandom);
        Qa       = $urandom;
        Qb       = $urandom;
    endtask

    task automatic rand_fwd();
        ExFwdValid  = 1'($urandom);
        ExFwdWe     = 1'($urandom);
        ExFwdIsLoad = 1'($urandom);
        ExFwdWr     = 5'($urandom_range(0, 3));
        ExFwdD      = $urandom;
        MemFwdWe    = 1'($urandom);
        MemFwdWr    = 5'($urandom_range(0, 3));
        MemFwdD     = $urandom;
        WbWe        = 1'($urandom);
        WbWr        = 5'($urandom_range(0, 3));
        WbD         = $urandom;
    endtask

    task automatic quiet_fwd();
        ExFwdValid = 0; ExFwdWe = 0; ExFwdIsLoad = 0; MemFwdWe = 0; WbWe = 0;
    endtask

    task automatic test_reset();
        rand_id(); rand_fwd();
        Hold = 1'($urandom); Flush = 1'($urandom);
        Clr = 1;
        tick(); tick();
        total++; if (ExValid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", ExValid); else passed++;
        total++; if ({ExA, ExB, ExImm} !== 96'h0) $display("FAIL rst_data got=%h %h %h exp=0", ExA, ExB, ExImm); else passed++;
        total++; if ({ExCtrl, ExRt, ExDst} !== 22'h0) $display("FAIL rst_ctl got=%h %h %h exp=0", ExCtrl, ExRt, ExDst); else passed++;
        Clr = 0; Hold = 0; Flush = 0; quiet_fwd();
        IdValid = 1; Qa = 32'h11; Qb = 32'h22; IdRs = 3; IdRt = 4; IdUsesRt = 1;
        tick();
        total++; if (ExA !== 32'h11 || ExB !== 32'h22) $display("FAIL first_op got=%h %h exp=11 22", ExA, ExB); else passed++;
        total++; if (ExValid !== 1'b1) $display("FAIL first_valid got=%b exp=1", ExValid); else passed++;
    endtask

    task automatic test_priority();
        quiet_fwd();
        IdValid = 1; IdRs = 5; IdRt = 1; Qa = 32'h5555;
        ExFwdValid = 1; ExFwdWe = 1; ExFwdWr = 5; ExFwdD = 32'hAAAA;
        MemFwdWe = 1; MemFwdWr = 5; MemFwdD = 32'hBBBB;
        WbWe = 1; WbWr = 5; WbD = 32'hCCCC;
        tick();
        total++; if (ExA !== 32'hAAAA) $display("FAIL prio_ex got=%h exp=aaaa", ExA); else passed++;
        ExFwdValid = 0;
        tick();
        total++; if (ExA !== 32'hBBBB) $display("FAIL prio_mem got=%h exp=bbbb", ExA); else passed++;
        MemFwdWe = 0;
        tick();
        total++; if (ExA !== 32'hCCCC) $display("FAIL prio_wb got=%h exp=cccc", ExA); else passed++;
        WbWe = 0;
        tick();
        total++; if (ExA !== 32'h5555) $display("FAIL prio_rf got=%h exp=5555", ExA); else passed++;
    endtask

    task automatic test_r0();
        IdValid = 1; IdRs = 0; IdRt = 0; IdUsesRt = 1; Qa = 32'h1357; Qb = 32'h2468;
        ExFwdValid = 1; ExFwdWe = 1; ExFwdIsLoad = 1; ExFwdWr = 0; ExFwdD = 32'hFFFF_FFFF;
        MemFwdWe = 1; MemFwdWr = 0; MemFwdD = 32'hFFFF_FFFF;
        WbWe = 1; WbWr = 0; WbD = 32'hFFFF_FFFF;
        #1;
        total++; if (LoadUseStall !== 1'b0) $display("FAIL r0_stall got=%b exp=0", LoadUseStall); else passed++;
        tick();
        total++; if (ExA !== 32'h0 || ExB !== 32'h0) $display("FAIL r0_data got=%h %h exp=0 0", ExA, ExB); else passed++;
        total++; if (ExValid !== 1'b1) $display("FAIL r0_valid got=%b exp=1", ExValid); else passed++;
    endtask

    task automatic test_load_use();
        quiet_fwd();
        IdValid = 1; IdRs = 1; IdRt = 7; IdUsesRt = 1; Qa = 32'h10; Qb = 32'h70;
        ExFwdValid = 1; ExFwdWe = 1; ExFwdIsLoad = 1; ExFwdWr = 7; ExFwdD = 32'hDEAD;
        #1;
        total++; if (LoadUseStall !== 1'b1) $display("FAIL lu_stall got=%b exp=1", LoadUseStall); else passed++;
        tick();
        total++; if (ExValid !== 1'b0 || ExB !== 32'h0) $display("FAIL lu_bubble got=%b %h exp=0 0", ExValid, ExB); else passed++;
        // the load has advanced to MEM
        ExFwdValid = 0; MemFwdWe = 1; MemFwdWr = 7; MemFwdD = 32'h1234;
        #1;
        total++; if (LoadUseStall !== 1'b0) $display("FAIL lu_restall got=%b exp=0", LoadUseStall); else passed++;
        tick();
        total++; if (ExB !== 32'h1234 || ExValid !== 1'b1) $display("FAIL lu_mem got=%h %b exp=1234 1", ExB, ExValid); else passed++;
        MemFwdWe = 0; IdUsesRt = 0;
        ExFwdValid = 1; ExFwdWe = 1; ExFwdIsLoad = 1; ExFwdWr = 7;
        #1;
        total++; if (LoadUseStall !== 1'b0) $display("FAIL lu_nort got=%b exp=0", LoadUseStall); else passed++;
        tick();
        total++; if (ExValid !== 1'b1 || ExB !== 32'h70) $display("FAIL lu_nort_out got=%b %h exp=1 70", ExValid, ExB); else passed++;
    endtask

    task automatic test_hold();
        quiet_fwd();
        IdValid = 1; IdRs = 2; IdRt = 6; IdUsesRt = 1; Qa = 32'h5A5A_0001; Qb = 32'hA5A5_0002;
        IdImm = 32'hFFFF_FF80; IdCtrl = 12'hABC; IdDst = 5'd9;
        tick();
        Hold = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(); rand_fwd();
            tick();
            total++;
            if ({ExValid, ExA, ExB, ExImm, ExCtrl, ExRt, ExDst} !==
                {1'b1, 32'h5A5A_0001, 32'hA5A5_0002, 32'hFFFF_FF80, 12'hABC, 5'd6, 5'd9})
                $display("FAIL hold_%0d got=%b %h %h %h %h %0d %0d", i, ExValid, ExA, ExB, ExImm, ExCtrl, ExRt, ExDst);
            else passed++;
        end
        IdValid = 1; IdRs = 3; ExFwdValid = 1; ExFwdWe = 1; ExFwdIsLoad = 1; ExFwdWr = 3;
        #1;
        total++; if (LoadUseStall !== 1'b0) $display("FAIL hold_stall got=%b exp=0", LoadUseStall); else passed++;
        tick();
        Hold = 0;
    endtask

    task automatic test_flush_clr();
        quiet_fwd();
        IdValid = 1; IdRs = 2; Qa = 32'h77;
        tick();
        total++; if (ExValid !== 1'b1) $display("FAIL fl_pre got=%b exp=1", ExValid); else passed++;
        Flush = 1; Hold = 1;
        tick();
        total++; if (ExValid !== 1'b0 || ExA !== 32'h0) $display("FAIL fl_hold got=%b %h exp=0 0", ExValid, ExA); else passed++;
        Flush = 0; Hold = 0;
        IdValid = 1; IdRs = 9; ExFwdValid = 1; ExFwdWe = 1; ExFwdIsLoad = 1; ExFwdWr = 9;
        #1;
        total++; if (LoadUseStall !== 1'b1) $display("FAIL clr_pre got=%b exp=1", LoadUseStall); else passed++;
        Clr = 1;
        tick();
        total++; if (ExValid !== 1'b0 || ExA !== 32'h0 || ExDst !== 5'd0) $display("FAIL clr_mid got=%b %h %0d exp=0", ExValid, ExA, ExDst); else passed++;
        Clr = 0;
        #1;
        total++; if (LoadUseStall !== 1'b1) $display("FAIL clr_post got=%b exp=1", LoadUseStall); else passed++;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rand_id(); rand_fwd();
            Clr   = ($urandom_range(0, 19) == 0);
            Hold  = ($urandom_range(0, 5) == 0);
            Flush = ($urandom_range(0, 7) == 0);
            #1;
            total++; if (LoadUseStall !== m_stall()) $display("FAIL rnd_stall_%0d got=%b exp=%b", i, LoadUseStall, m_stall()); else passed++;
            tick();
            total++;
            if ({ExValid, ExA, ExB, ExImm, ExCtrl, ExRt, ExDst} !== {e_valid, e_a, e_b, e_imm, e_ctrl, e_rt, e_dst})
                $display("FAIL rnd_out_%0d got=%b %h %h %h %h %0d %0d exp=%b %h %h %h %h %0d %0d", i,
                         ExValid, ExA, ExB, ExImm, ExCtrl, ExRt, ExDst,
                         e_valid, e_a, e_b, e_imm, e_ctrl, e_rt, e_dst);
            else passed++;
        end
        Clr = 0; Hold = 0; Flush = 0;
    endtask

    initial begin
        {e_valid, e_a, e_b, e_imm, e_ctrl, e_rt, e_dst} = '0;
        Clr = 1; Hold = 0; Flush = 0;
        rand_id(); quiet_fwd();
        ExFwdWr = 0; ExFwdD = 0; MemFwdWr = 0; MemFwdD = 0; WbWr = 0; WbD = 0;
        test_reset();
        test_priority();
        test_r0();
        test_load_use();
        test_hold();
        test_flush_clr();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline stage directly downstream of the 32x32 register file; consumes read ports Qa/Qb for source registers Rs/Rt.
- Resolves RAW hazards by bypassing from EX, MEM and WB producers; detects load-use hazards and inserts bubbles.
- Registers the resolved operands, immediate and control bundle for the EX stage.

Parameters:
- CTRL_W, 12, width of the decoded control bundle passed through to EX.

Ports:
- Clk in 1: clock; all state updates on rising edge.
- Clr in 1: synchronous, active-high reset.
- IdValid in 1: ID slot holds a real instruction.
- IdRs in 5: source register A; also drives register file Ra.
- IdRt in 5: source register B; also drives register file Rb.
- IdUsesRt in 1: instruction reads Rt; if 0, Rt takes no part in hazard checks.
- IdDst in 5: destination register, passed through.
- IdImm in 32: sign/zero-extended immediate, passed through.
- IdCtrl in CTRL_W: decoded control, passed through.
- Qa in 32: register file read data for IdRs.
- Qb in 32: register file read data for IdRt.
- ExFwdValid, ExFwdWe in 1 each: producer currently in EX.
- ExFwdIsLoad in 1: producer currently in EX is a load.
- ExFwdWr in 5, ExFwdD in 32: EX producer destination and result.
- MemFwdWe in 1, MemFwdWr in 5, MemFwdD in 32: MEM producer.
- WbWe in 1, WbWr in 5, WbD in 32: the same signals that drive register file We/Wr/D.
- Hold in 1: downstream stall; freeze this stage.
- Flush in 1: kill the ID instruction (branch/jump redirect).
- LoadUseStall out 1: to IF/ID; hold PC and the IF/ID register this cycle.
- ExValid out 1, ExA out 32, ExB out 32, ExImm out 32, ExCtrl out CTRL_W, ExRt out 5, ExDst out 5: registered outputs to EX.

Behaviour:
- Reset (Clr=1 at edge): ExValid=0; ExA, ExB, ExImm, ExCtrl, ExRt and ExDst all 0. Clr overrides all other inputs.
- Operand select per source, combinational. Sources in priority order:
  - index 0: always 32'h0; no bypass, no hazard.
  - EX: when ExFwdValid & ExFwdWe & ExFwdWr==idx & !ExFwdIsLoad → ExFwdD.
  - MEM: when MemFwdWe & MemFwdWr==idx → MemFwdD.
  - WB: when WbWe & WbWr==idx → WbD. Covers the register file write landing on the same edge as the read.
  - Otherwise: Qa or Qb.
- LoadUseStall = IdValid & ExFwdValid & ExFwdWe & ExFwdIsLoad & ExFwdWr!=0 & (ExFwdWr==IdRs | (IdUsesRt & ExFwdWr==IdRt)).
  - Forced to 0 while Hold=1.
  - Forced to 0 while Flush=1.
- Register update priority at each edge:
  1. Clr: reset.
  2. Flush: ExValid←0; data registers don't-care but must load 0.
  3. Hold: all outputs keep their value.
  4. LoadUseStall: bubble; ExValid←0, data registers←0.
  5. Otherwise: ExValid←IdValid; ExA/ExB←selected operands; remaining fields←ID inputs.
- Latency: 1 cycle from ID inputs to Ex* outputs.
- A stalled instruction re-presents next cycle. The load has moved to MEM, so the operand is then taken from the MEM bypass; no second bubble.
- IdValid=0: no stall is raised; the stage still loads (ExValid←0).

Decomposition:
- Shared package (cpu_pkg): REG_W=5, DATA_W=32, CTRL_W default, and the forwarding-select enum {FWD_RF, FWD_EX, FWD_MEM, FWD_WB, FWD_ZERO}.
- One sub-module, fwd_sel: combinational priority select for one operand. Returns the data and the select code, the code for debug/coverage. Instantiated twice (Rs and Rt).

Test Plan:
1. Clr=1 for 2 cycles with random inputs → all outputs 0, ExValid=0. Release with IdValid=1, Qa=32'h11, Qb=32'h22, IdRs=3, IdRt=4, no producers → next cycle ExA=32'h11, ExB=32'h22, ExValid=1.
2. Priority bypass: IdRs=5 with EX (ExFwdD=32'hAAAA), MEM (32'hBBBB) and WB (32'hCCCC) all writing r5 → ExA=32'hAAAA. Drop the EX producer → 32'hBBBB. Drop MEM → 32'hCCCC.
3. r0: IdRs=0, all producers write r0 with 32'hFFFF_FFFF → ExA=0, LoadUseStall=0.
4. Load-use: EX load to r7, IdRt=7, IdUsesRt=1 → LoadUseStall=1, next ExValid=0. Following cycle: MemFwdWr=7, MemFwdD=32'h1234 → ExB=32'h1234, ExValid=1. Repeat with IdUsesRt=0 → no stall.
5. Hold=1 for 3 cycles while the ID inputs change → Ex* outputs unchanged. Hold with a load-use condition present → LoadUseStall=0.
6. Flush and Hold asserted together with IdValid=1 → ExValid=0 after the edge. Clr asserted mid-stall → outputs 0, LoadUseStall from the same inputs unaffected next cycle.
